// File: rtl/ahb_arbiter_if.sv
// Arbitration-side bundle between the AHB-lite masters/interconnect and ahb_arbiter.
// The arbiter uses the slave view; a master-side model uses the master view.
interface ahb_arbiter_if #(
   parameter int NUM_MASTERS = 4
);
   localparam int MW = $clog2(NUM_MASTERS);

   logic [NUM_MASTERS-1:0] hbusreq;
   logic [NUM_MASTERS-1:0] hlock;
   logic [1:0]             htrans;
   logic [2:0]             hburst;
   logic                   hready;
   logic                   hresp;
   logic [NUM_MASTERS-1:0] hgrant;
   logic [MW-1:0]          hmaster;
   logic [MW-1:0]          hmaster_data;
   logic                   hmastlock;

   modport slave (
      input  hbusreq, hlock, htrans, hburst, hready, hresp,
      output hgrant, hmaster, hmaster_data, hmastlock
   );

   modport master (
      output hbusreq, hlock, htrans, hburst, hready, hresp,
      input  hgrant, hmaster, hmaster_data, hmastlock
   );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB-lite arbiter: keeps fixed bursts and locked sequences intact,
// hands over with zero bubble and parks on DEFAULT_MASTER when idle.
module ahb_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input logic         hclk,
   input logic         hresetn,
   ahb_arbiter_if.slave bus
);
   localparam int MW = $clog2(NUM_MASTERS);
   localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_BUSY   = 2'd1;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;

   logic [3:0]             rem;
   logic [3:0]             rem_next;
   logic [MW-1:0]          g_idx;
   logic [MW-1:0]          scan_idx;
   logic [MW-1:0]          next_idx;
   logic                   found;
   logic                   hold;
   logic [NUM_MASTERS-1:0] next_grant;

   // Address beats remaining after the NONSEQ beat of a burst (len - 1).
   function automatic logic [3:0] burst_rem(input logic [2:0] burst);
      case (burst)
         3'd2, 3'd3: burst_rem = 4'd3;
         3'd4, 3'd5: burst_rem = 4'd7;
         3'd6, 3'd7: burst_rem = 4'd15;
         default:    burst_rem = 4'd0;
      endcase
   endfunction

   always_comb begin
      g_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (bus.hgrant[i]) g_idx = MW'(i);
      end
   end

   always_comb begin
      case (bus.htrans)
         TR_NONSEQ: rem_next = burst_rem(bus.hburst);
         TR_SEQ:    rem_next = (rem == 4'd0) ? 4'd0 : rem - 4'd1;
         TR_BUSY:   rem_next = rem;
         TR_IDLE:   rem_next = 4'd0;
         default:   rem_next = 4'd0;
      endcase
   end

   // Current owner is scanned last so a lone requester keeps the bus.
   always_comb begin
      found    = 1'b0;
      next_idx = MW'(DEFAULT_MASTER);
      scan_idx = '0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         scan_idx = MW'((int'(g_idx) + i) % NUM_MASTERS);
         if (!found && bus.hbusreq[scan_idx]) begin
            found    = 1'b1;
            next_idx = scan_idx;
         end
      end
   end

   always_comb begin
      next_grant           = '0;
      next_grant[next_idx] = 1'b1;
   end

   // Releasing at rem_next == 1 lets the next owner take over right after the last beat.
   assign hold = (rem_next > 4'd1) || (bus.hlock[g_idx] && bus.hbusreq[g_idx]);

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         bus.hgrant       <= DEF_GRANT;
         bus.hmaster      <= MW'(DEFAULT_MASTER);
         bus.hmaster_data <= MW'(DEFAULT_MASTER);
         bus.hmastlock    <= 1'b0;
         rem              <= 4'd0;
      end else if (bus.hready) begin
         rem              <= rem_next;
         if (!hold) bus.hgrant <= next_grant;
         bus.hmaster      <= g_idx;
         bus.hmaster_data <= bus.hmaster;
         bus.hmastlock    <= bus.hlock[g_idx];
      end else if (bus.hresp) begin
         // First ERROR cycle: the burst is abandoned.
         rem <= 4'd0;
      end
   end
endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an integer reference model.
module tb_ahb_arbiter;
   localparam int N   = 4;
   localparam int DEF = 0;
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;

   logic hclk = 1'b0;
   logic hresetn;
   ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

   ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
      .hclk   (hclk),
      .hresetn(hresetn),
      .bus    (bus)
   );

   always #5 hclk = ~hclk;

   int n_cmp = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Reference model state: plain integers.
   int m_g, m_master, m_mdata, m_rem;
   bit m_lock;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int beats(input int b);
      case (b)
         0, 1:    return 1;
         2, 3:    return 4;
         4, 5:    return 8;
         default: return 16;
      endcase
   endfunction

   function automatic bit bit_of(input int v, input int idx);
      return ((v >> idx) & 1) != 0;
   endfunction

   task automatic model_edge();
      int rn, ng, req, lck;
      bit hold;
      req = int'(bus.hbusreq);
      lck = int'(bus.hlock);
      if (!hresetn) begin
         m_g = DEF; m_master = DEF; m_mdata = DEF; m_lock = 1'b0; m_rem = 0;
      end else if (bus.hready) begin
         case (int'(bus.htrans))
            2:       rn = beats(int'(bus.hburst)) - 1;
            3:       rn = (m_rem > 0) ? m_rem - 1 : 0;
            1:       rn = m_rem;
            default: rn = 0;
         endcase
         hold = (rn > 1) || (bit_of(lck, m_g) && bit_of(req, m_g));
         ng = m_g;
         if (!hold) begin
            ng = DEF;
            for (int i = N; i >= 1; i--)
               if (bit_of(req, (m_g + i) % N)) ng = (m_g + i) % N;
         end
         m_mdata  = m_master;
         m_master = m_g;
         m_lock   = bit_of(lck, m_g);
         m_g      = ng;
         m_rem    = rn;
      end else if (bus.hresp) begin
         m_rem = 0;
      end
   endtask

   always @(negedge hclk) begin
      if (chk_en) begin
         chk("hgrant", int'(bus.hgrant), 1 << m_g);
         chk("hmaster", int'(bus.hmaster), m_master);
         chk("hmaster_data", int'(bus.hmaster_data), m_mdata);
         chk("hmastlock", int'(bus.hmastlock), int'(m_lock));
      end
   end

   task automatic step(input bit rstn, input logic [N-1:0] req, input logic [N-1:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu, input bit rdy, input bit rsp);
      hresetn     = rstn;
      bus.hbusreq = req;
      bus.hlock   = lck;
      bus.htrans  = tr;
      bus.hburst  = bu;
      bus.hready  = rdy;
      bus.hresp   = rsp;
      @(posedge hclk);
      model_edge();
      @(negedge hclk);
   endtask

   task automatic go(input logic [N-1:0] req, input logic [N-1:0] lck,
                     input logic [1:0] tr, input logic [2:0] bu);
      step(1'b1, req, lck, tr, bu, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, '0, '0, IDLE, 3'd0, 1'b1, 1'b0);
   endtask

   initial begin
      int exp_m[6];
      int prev;
      exp_m = '{0, 1, 2, 3, 0, 1};

      // Reset mid-INCR8
      do_reset();
      chk_en = 1'b1;
      go(4'b0001, '0, NONSEQ, 3'd5);
      go(4'b0001, '0, SEQ, 3'd5);
      go(4'b0001, '0, SEQ, 3'd5);
      step(1'b0, 4'b0010, '0, SEQ, 3'd5, 1'b1, 1'b0);
      step(1'b0, 4'b0010, '0, SEQ, 3'd5, 1'b1, 1'b0);
      chk("rst_hgrant", int'(bus.hgrant), 1);
      chk("rst_hmaster", int'(bus.hmaster), 0);
      chk("rst_hmaster_data", int'(bus.hmaster_data), 0);
      chk("rst_hmastlock", int'(bus.hmastlock), 0);
      go(4'b0010, '0, BUSY, 3'd0);
      chk("rst_rem_cleared_grant", int'(bus.hgrant), 2);

      // Round-robin with all requesting
      do_reset();
      chk("rr_hmaster_reset", int'(bus.hmaster), 0);
      prev = 0;
      for (int i = 0; i < 6; i++) begin
         go(4'b1111, '0, NONSEQ, 3'd0);
         chk("rr_hmaster", int'(bus.hmaster), exp_m[i]);
         chk("rr_hmaster_data", int'(bus.hmaster_data), prev);
         prev = exp_m[i];
      end

      // INCR4 by master 2 with master 0 waiting
      do_reset();
      go(4'b0100, '0, IDLE, 3'd0);
      go(4'b0100, '0, IDLE, 3'd0);
      go(4'b0101, '0, NONSEQ, 3'd3);
      chk("burst_A0_hgrant", int'(bus.hgrant), 4);
      go(4'b0101, '0, SEQ, 3'd3);
      chk("burst_A1_hgrant", int'(bus.hgrant), 4);
      go(4'b0101, '0, SEQ, 3'd3);
      chk("burst_A2_hgrant", int'(bus.hgrant), 1);
      chk("burst_A2_hmaster", int'(bus.hmaster), 2);
      go(4'b0101, '0, SEQ, 3'd3);
      chk("burst_A3_hmaster", int'(bus.hmaster), 0);

      // WRAP8 with wait states on A1
      do_reset();
      go(4'b0010, '0, IDLE, 3'd0);
      go(4'b0010, '0, IDLE, 3'd0);
      go(4'b0101, '0, NONSEQ, 3'd4);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 4'b0101, '0, SEQ, 3'd4, 1'b0, 1'b0);
         chk("wait_hgrant", int'(bus.hgrant), 2);
         chk("wait_hmaster", int'(bus.hmaster), 1);
         chk("wait_hmaster_data", int'(bus.hmaster_data), 1);
      end
      for (int i = 1; i <= 5; i++) begin
         go(4'b0101, '0, SEQ, 3'd4);
         chk("wrap8_hold_hgrant", int'(bus.hgrant), 2);
      end
      go(4'b0101, '0, SEQ, 3'd4);
      chk("wrap8_A6_hgrant", int'(bus.hgrant), 4);
      go(4'b0101, '0, SEQ, 3'd4);

      // Locked SINGLEs by master 1
      do_reset();
      go(4'b0010, '0, IDLE, 3'd0);
      for (int i = 0; i < 5; i++) begin
         go(4'b1111, 4'b0010, NONSEQ, 3'd0);
         chk("lock_hmaster", int'(bus.hmaster), 1);
         chk("lock_hmastlock", int'(bus.hmastlock), 1);
         chk("lock_hgrant", int'(bus.hgrant), 2);
      end
      go(4'b1111, 4'b0000, NONSEQ, 3'd0);
      chk("unlock_hgrant", int'(bus.hgrant), 4);
      chk("unlock_hmastlock", int'(bus.hmastlock), 0);

      // ERROR during INCR16 by master 3
      do_reset();
      go(4'b1000, '0, IDLE, 3'd0);
      go(4'b1000, '0, IDLE, 3'd0);
      go(4'b1001, '0, NONSEQ, 3'd7);
      go(4'b1001, '0, SEQ, 3'd7);
      go(4'b1001, '0, SEQ, 3'd7);
      chk("err_pre_hgrant", int'(bus.hgrant), 8);
      step(1'b1, 4'b1001, '0, SEQ, 3'd7, 1'b0, 1'b1);
      chk("err_wait_hgrant", int'(bus.hgrant), 8);
      step(1'b1, 4'b1001, '0, BUSY, 3'd7, 1'b1, 1'b1);
      chk("err_after_hgrant", int'(bus.hgrant), 1);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 99) != 0,
              N'($urandom),
              ($urandom_range(0, 3) == 0) ? N'($urandom) : N'(0),
              2'($urandom),
              3'($urandom),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) == 0);
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
